urt_rx_pkg_parse: RTL

URT_RX_PKG_PARSE -- requirements
Module: urt_rx_pkg_parse

---
 rtl/urt_rx_pkg_parse.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/urt_rx_pkg_parse.sv
// UART receive packet parser: SYN(2) CMD ID [D3..D0] CHK, modulo-256 checksum.
// Decodes read requests into a one-hot pulse and writes into an id/data strobe.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | hunting for the sync high byte
// SYN2  | sync high seen, expecting sync low
// CMD   | sync word complete, expecting read/write command
// ID    | command accepted, expecting register id (0..19)
// DATA  | write only: collecting four data bytes, MSB first
// CHK   | expecting checksum byte; match issues the command
module urt_rx_pkg_parse #(
    parameter logic [15:0] SYN_CODE    = 16'hACAC,
    parameter logic [7:0]  CMD_RD      = 8'hA0,
    parameter logic [7:0]  CMD_WR      = 8'hA1,
    parameter int          TIMEOUT_CYC = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  i_rx_dat,
    input  logic        i_rx_vld,
    output logic [19:0] o_rd_req,
    output logic        o_wr_vld,
    output logic [4:0]  o_wr_id,
    output logic [31:0] o_wr_dat,
    output logic        o_pkt_err
);

    localparam logic [7:0] SYN_HI  = SYN_CODE[15:8];
    localparam logic [7:0] SYN_LO  = SYN_CODE[7:0];
    localparam int         TW      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {S_IDLE, S_SYN2, S_CMD, S_ID, S_DATA, S_CHK} state_t;

    state_t        state, state_nxt;
    logic [7:0]    sum, sum_nxt;
    logic          is_wr, is_wr_nxt;
    logic [4:0]    id, id_nxt;
    logic [31:0]   shift, shift_nxt;
    logic [1:0]    byte_cnt, byte_cnt_nxt;
    logic [TW-1:0] to_cnt;
    logic          expire;

    logic [19:0]   rd_req_nxt;
    logic          wr_vld_nxt;
    logic [4:0]    wr_id_nxt;
    logic [31:0]   wr_dat_nxt;
    logic          pkt_err_nxt;

    // A received byte on the expiry cycle wins, so expiry needs an idle cycle.
    assign expire = !i_rx_vld && (state != S_IDLE) && (to_cnt == TO_LAST);

    // Inter-byte idle counter, saturating; only runs inside a packet.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt <= '0;
        end else if (i_rx_vld || state == S_IDLE || expire) begin
            to_cnt <= '0;
        end else if (to_cnt != TO_LAST) begin
            to_cnt <= to_cnt + TW'(1);
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            sum       <= '0;
            is_wr     <= 1'b0;
            id        <= '0;
            shift     <= '0;
            byte_cnt  <= '0;
            o_rd_req  <= '0;
            o_wr_vld  <= 1'b0;
            o_wr_id   <= '0;
            o_wr_dat  <= '0;
            o_pkt_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            sum       <= sum_nxt;
            is_wr     <= is_wr_nxt;
            id        <= id_nxt;
            shift     <= shift_nxt;
            byte_cnt  <= byte_cnt_nxt;
            o_rd_req  <= rd_req_nxt;
            o_wr_vld  <= wr_vld_nxt;
            o_wr_id   <= wr_id_nxt;
            o_wr_dat  <= wr_dat_nxt;
            o_pkt_err <= pkt_err_nxt;
        end
    end

    // Next-state and next-output decode, one byte per valid strobe.
    always_comb begin
        state_nxt    = state;
        sum_nxt      = sum;
        is_wr_nxt    = is_wr;
        id_nxt       = id;
        shift_nxt    = shift;
        byte_cnt_nxt = byte_cnt;
        rd_req_nxt   = '0;
        wr_vld_nxt   = 1'b0;
        wr_id_nxt    = o_wr_id;
        wr_dat_nxt   = o_wr_dat;
        pkt_err_nxt  = 1'b0;

        if (i_rx_vld) begin
            case (state)
                S_IDLE: begin
                    if (i_rx_dat == SYN_HI) state_nxt = S_SYN2;
                end
                S_SYN2: begin
                    if (i_rx_dat == SYN_LO)      state_nxt = S_CMD;
                    else if (i_rx_dat == SYN_HI) state_nxt = S_SYN2;
                    else                         state_nxt = S_IDLE;
                end
                S_CMD: begin
                    if (i_rx_dat == CMD_RD || i_rx_dat == CMD_WR) begin
                        state_nxt = S_ID;
                        sum_nxt   = i_rx_dat;
                        is_wr_nxt = (i_rx_dat == CMD_WR);
                    end else if (i_rx_dat == SYN_HI) begin
                        state_nxt = S_SYN2;
                    end else begin
                        state_nxt   = S_IDLE;
                        pkt_err_nxt = 1'b1;
                    end
                end
                S_ID: begin
                    if (i_rx_dat <= 8'd19) begin
                        id_nxt       = i_rx_dat[4:0];
                        sum_nxt      = sum + i_rx_dat;
                        byte_cnt_nxt = '0;
                        state_nxt    = is_wr ? S_DATA : S_CHK;
                    end else begin
                        state_nxt   = S_IDLE;
                        pkt_err_nxt = 1'b1;
                    end
                end
                S_DATA: begin
                    shift_nxt    = {shift[23:0], i_rx_dat};
                    sum_nxt      = sum + i_rx_dat;
                    byte_cnt_nxt = byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) state_nxt = S_CHK;
                end
                S_CHK: begin
                    state_nxt = S_IDLE;
                    if (i_rx_dat == sum) begin
                        if (is_wr) begin
                            wr_vld_nxt = 1'b1;
                            wr_id_nxt  = id;
                            wr_dat_nxt = shift;
                        end else begin
                            rd_req_nxt = 20'd1 << id;
                        end
                    end else begin
                        pkt_err_nxt = 1'b1;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end else if (expire) begin
            state_nxt   = S_IDLE;
            pkt_err_nxt = 1'b1;
        end
    end

endmodule
